// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush scheduler:
// reset level, stall bit positions, stall patterns, FSM states.
package pipeline_ctrl_pkg;

   localparam logic RST_ENABLE = 1'b0;
   localparam logic TRUE       = 1'b1;
   localparam logic FALSE      = 1'b0;

   localparam int unsigned ADDR_BUS  = 32;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Hold bits: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
   localparam int unsigned STALL_PC = 0;
   localparam int unsigned STALL_IF = 1;
   localparam int unsigned STALL_ID = 2;
   localparam int unsigned STALL_EX = 3;
   localparam int unsigned STALL_WB = 4;
   localparam int unsigned STALL_W  = 5;

   localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
   localparam logic [STALL_W-1:0] STALL_MEMV = 5'b01111;
   localparam logic [STALL_W-1:0] STALL_IDV  = 5'b00011;
   localparam logic [STALL_W-1:0] STALL_IFV  = 5'b00001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PEND_BR = 2'd1,
      ST_DSLOT   = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/pipeline_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and pulses
// timeout_o in the cycle the count reaches WDOG_CYCLES.
// Ports: clk, rst (sync, active-low), stalled_i, clear_i, timeout_o.
module pipeline_stall_wdog
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic stalled_i,
   input  logic clear_i,
   output logic timeout_o
);

   localparam int unsigned CNT_W =
      (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam int unsigned LAST =
      (WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1;
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);
   localparam logic ENABLE = (WDOG_CYCLES != 0);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Counter only ever reaches LAST, then restarts, so it never wraps.
   always_comb begin
      cnt_d     = cnt_q;
      timeout_o = FALSE;
      if (!ENABLE || clear_i || !stalled_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST_C) begin
         timeout_o = TRUE;
         cnt_d     = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler: stall priority, branch redirect
// with pending-target hold, delay-slot flag, exception flush.
// Ports: clk, rst, stall_req_{if,id,mem}, branch_flag/addr,
// exc_flag/addr -> stall, flush, redirect_en/addr,
// next_in_delay_slot, stall_timeout.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned WDOG_CYCLES = 1024,
   parameter int unsigned ADDR_W      = ADDR_BUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_req_if,
   input  logic              stall_req_id,
   input  logic              stall_req_mem,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              exc_flag,
   input  logic [ADDR_W-1:0] exc_addr,
   output logic [4:0]        stall,
   output logic              flush,
   output logic              redirect_en,
   output logic [ADDR_W-1:0] redirect_addr,
   output logic              next_in_delay_slot,
   output logic              stall_timeout
);

   ctrl_state_e       state_q;
   ctrl_state_e       state_d;
   logic [ADDR_W-1:0] tgt_q;
   logic [ADDR_W-1:0] tgt_d;
   logic [4:0]        stall_v;
   logic              in_rst;
   logic              br_take;

   // Outputs are forced quiet while reset is held.
   assign in_rst = (rst == RST_ENABLE);

   always_comb begin
      stall_v = STALL_NONE;
      if (!in_rst && !exc_flag) begin
         if (stall_req_mem) begin
            stall_v = STALL_MEMV;
         end else if (stall_req_id) begin
            stall_v = STALL_IDV;
         end else if (stall_req_if) begin
            stall_v = STALL_IFV;
         end
      end
   end

   assign stall   = stall_v;
   assign br_take = branch_flag & ~stall_v[STALL_ID];

   always_comb begin
      state_d            = state_q;
      tgt_d              = tgt_q;
      flush              = FALSE;
      redirect_en        = FALSE;
      redirect_addr      = '0;
      next_in_delay_slot = FALSE;
      if (in_rst) begin
         state_d = ST_IDLE;
         tgt_d   = '0;
      end else if (exc_flag) begin
         flush         = TRUE;
         redirect_en   = TRUE;
         redirect_addr = exc_addr;
         state_d       = ST_IDLE;
         tgt_d         = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (br_take) begin
                  if (!stall_v[STALL_PC]) begin
                     redirect_en   = TRUE;
                     redirect_addr = branch_addr;
                     state_d       = ST_DSLOT;
                  end else begin
                     // PC frozen: keep target so the delay slot
                     // is still fetched before redirecting.
                     tgt_d   = branch_addr;
                     state_d = ST_PEND_BR;
                  end
               end
            end
            ST_PEND_BR: begin
               if (!stall_v[STALL_PC]) begin
                  redirect_en   = TRUE;
                  redirect_addr = tgt_q;
                  tgt_d         = '0;
                  state_d       = ST_DSLOT;
               end
            end
            ST_DSLOT: begin
               next_in_delay_slot = TRUE;
               if (!stall_v[STALL_IF]) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   pipeline_stall_wdog #(
      .WDOG_CYCLES(WDOG_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .stalled_i(|stall_v),
      .clear_i  (exc_flag),
      .timeout_o(stall_timeout)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (watchdog set to 8 cycles).
// Expected outputs are queued per driven cycle and compared on negedge.
module tb_pipeline_ctrl;

   typedef struct packed {
      logic        r;
      logic        fi;
      logic        fd;
      logic        fm;
      logic        b;
      logic [31:0] ba;
      logic        x;
      logic [31:0] xa;
   } stim_t;

   typedef struct packed {
      logic [4:0]  st;
      logic        fl;
      logic        re;
      logic [31:0] ra;
      logic        ds;
      logic        to;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_req_if;
   logic        stall_req_id;
   logic        stall_req_mem;
   logic        branch_flag;
   logic [31:0] branch_addr;
   logic        exc_flag;
   logic [31:0] exc_addr;
   logic [4:0]  stall;
   logic        flush;
   logic        redirect_en;
   logic [31:0] redirect_addr;
   logic        next_in_delay_slot;
   logic        stall_timeout;

   obs_t exp_q[$];
   obs_t got;
   obs_t want;
   int   checks   = 0;
   int   failures = 0;

   localparam logic [31:0] BA  = 32'h0040_0100;
   localparam logic [31:0] BA2 = 32'h0050_0000;
   localparam logic [31:0] EA  = 32'hBFC0_0380;
   localparam logic [31:0] EA2 = 32'h8000_0180;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .WDOG_CYCLES(8),
      .ADDR_W     (32)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall_req_if      (stall_req_if),
      .stall_req_id      (stall_req_id),
      .stall_req_mem     (stall_req_mem),
      .branch_flag       (branch_flag),
      .branch_addr       (branch_addr),
      .exc_flag          (exc_flag),
      .exc_addr          (exc_addr),
      .stall             (stall),
      .flush             (flush),
      .redirect_en       (redirect_en),
      .redirect_addr     (redirect_addr),
      .next_in_delay_slot(next_in_delay_slot),
      .stall_timeout     (stall_timeout)
   );

   assign got = {stall, flush, redirect_en, redirect_addr,
                 next_in_delay_slot, stall_timeout};

   function automatic stim_t S(input logic r, fi, fd, fm, b,
                               input logic [31:0] ba,
                               input logic x,
                               input logic [31:0] xa);
      S = '{r, fi, fd, fm, b, ba, x, xa};
   endfunction

   function automatic obs_t O(input logic [4:0] st,
                              input logic fl, re,
                              input logic [31:0] ra,
                              input logic ds, to);
      O = '{st, fl, re, ra, ds, to};
   endfunction

   function automatic stim_t IDLE();
      IDLE = S(1, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic obs_t ZERO();
      ZERO = O(5'b00000, 0, 0, 0, 0, 0);
   endfunction

   task automatic drive(input stim_t s, input obs_t e);
      @(posedge clk);
      #1;
      rst           = s.r;
      stall_req_if  = s.fi;
      stall_req_id  = s.fd;
      stall_req_mem = s.fm;
      branch_flag   = s.b;
      branch_addr   = s.ba;
      exc_flag      = s.x;
      exc_addr      = s.xa;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      stim_t s[$];
      obs_t  e[$];
      for (int i = 0; i < 3; i++) begin
         s.push_back(S(0, 1, 1, 1, 1, BA, 1, EA));
         e.push_back(ZERO());
      end
      s.push_back(IDLE()); e.push_back(ZERO());
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i], e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL reset step%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_branch();
      stim_t s[$];
      obs_t  e[$];
      s.push_back(S(1, 0, 0, 0, 1, BA, 0, 0));
      e.push_back(O(5'b00000, 0, 1, BA, 0, 0));
      s.push_back(IDLE()); e.push_back(O(5'b00000, 0, 0, 0, 1, 0));
      s.push_back(IDLE()); e.push_back(ZERO());
      // delay slot held in IF/ID by a load-use stall
      s.push_back(S(1, 0, 0, 0, 1, BA2, 0, 0));
      e.push_back(O(5'b00000, 0, 1, BA2, 0, 0));
      s.push_back(S(1, 0, 1, 0, 0, 0, 0, 0));
      e.push_back(O(5'b00011, 0, 0, 0, 1, 0));
      s.push_back(IDLE()); e.push_back(O(5'b00000, 0, 0, 0, 1, 0));
      s.push_back(IDLE()); e.push_back(ZERO());
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i], e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL branch step%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_pending_branch();
      stim_t s[$];
      obs_t  e[$];
      s.push_back(S(1, 1, 0, 0, 1, BA, 0, 0));
      e.push_back(O(5'b00001, 0, 0, 0, 0, 0));
      s.push_back(S(1, 1, 0, 0, 0, 0, 0, 0));
      e.push_back(O(5'b00001, 0, 0, 0, 0, 0));
      s.push_back(S(1, 1, 0, 0, 1, BA2, 0, 0));
      e.push_back(O(5'b00001, 0, 0, 0, 0, 0));
      s.push_back(S(1, 1, 0, 0, 0, 0, 0, 0));
      e.push_back(O(5'b00001, 0, 0, 0, 0, 0));
      s.push_back(S(1, 0, 0, 0, 1, BA2, 0, 0));
      e.push_back(O(5'b00000, 0, 1, BA, 0, 0));
      s.push_back(IDLE()); e.push_back(O(5'b00000, 0, 0, 0, 1, 0));
      s.push_back(IDLE()); e.push_back(ZERO());
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i], e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL pend_br step%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_stall_prio();
      stim_t s[$];
      obs_t  e[$];
      s.push_back(S(1, 0, 1, 1, 0, 0, 0, 0)); e.push_back(O(5'b01111, 0, 0, 0, 0, 0));
      s.push_back(S(1, 0, 1, 0, 0, 0, 0, 0)); e.push_back(O(5'b00011, 0, 0, 0, 0, 0));
      s.push_back(IDLE());                    e.push_back(ZERO());
      s.push_back(S(1, 1, 1, 0, 0, 0, 0, 0)); e.push_back(O(5'b00011, 0, 0, 0, 0, 0));
      s.push_back(S(1, 1, 0, 1, 0, 0, 0, 0)); e.push_back(O(5'b01111, 0, 0, 0, 0, 0));
      s.push_back(S(1, 0, 0, 1, 1, BA, 0, 0)); e.push_back(O(5'b01111, 0, 0, 0, 0, 0));
      s.push_back(IDLE());                    e.push_back(ZERO());
      s.push_back(S(1, 1, 1, 1, 0, 0, 1, EA2));
      e.push_back(O(5'b00000, 1, 1, EA2, 0, 0));
      s.push_back(IDLE());                    e.push_back(ZERO());
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i], e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL prio step%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_exception();
      stim_t s[$];
      obs_t  e[$];
      s.push_back(S(1, 1, 0, 0, 1, BA, 0, 0));
      e.push_back(O(5'b00001, 0, 0, 0, 0, 0));
      s.push_back(S(1, 1, 0, 0, 0, 0, 1, EA));
      e.push_back(O(5'b00000, 1, 1, EA, 0, 0));
      s.push_back(IDLE()); e.push_back(ZERO());
      s.push_back(S(1, 0, 0, 0, 1, BA, 1, EA));
      e.push_back(O(5'b00000, 1, 1, EA, 0, 0));
      s.push_back(IDLE()); e.push_back(ZERO());
      s.push_back(S(1, 0, 0, 0, 1, BA2, 0, 0));
      e.push_back(O(5'b00000, 0, 1, BA2, 0, 0));
      s.push_back(S(1, 0, 0, 0, 0, 0, 1, EA2));
      e.push_back(O(5'b00000, 1, 1, EA2, 0, 0));
      s.push_back(IDLE()); e.push_back(ZERO());
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i], e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL exc step%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t s[$];
      obs_t  e[$];
      s.push_back(S(1, 1, 0, 0, 1, BA, 0, 0));
      e.push_back(O(5'b00001, 0, 0, 0, 0, 0));
      s.push_back(S(0, 1, 0, 0, 0, 0, 0, 0)); e.push_back(ZERO());
      s.push_back(IDLE()); e.push_back(ZERO());
      s.push_back(IDLE()); e.push_back(ZERO());
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i], e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL rst_mid step%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_watchdog();
      stim_t s[$];
      obs_t  e[$];
      s.push_back(IDLE()); e.push_back(ZERO());
      for (int c = 0; c < 20; c++) begin
         s.push_back(S(1, 1, 0, 0, 0, 0, 0, 0));
         e.push_back(O(5'b00001, 0, 0, 0, 0,
                       (c == 7) || (c == 15)));
      end
      s.push_back(IDLE()); e.push_back(ZERO());
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i], e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL wdog step%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   initial begin
      rst           = 1'b0;
      stall_req_if  = 1'b0;
      stall_req_id  = 1'b0;
      stall_req_mem = 1'b0;
      branch_flag   = 1'b0;
      branch_addr   = '0;
      exc_flag      = 1'b0;
      exc_addr      = '0;
      test_reset();
      test_branch();
      test_pending_branch();
      test_stall_prio();
      test_exception();
      test_reset_mid();
      test_watchdog();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
